// File: rtl/pid_pwm_driver.sv
// pid_pwm_driver: shadow-buffered PWM stage for the PID control word; duty changes only at period wrap.
// Define PWM_DEADTIME_EN to add a dead-time FSM that drives the complementary pwm_n output.
module pid_pwm_driver #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter int DEAD     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             pwm_n,
  output logic             period_start
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] LAST = {{(WIDTH-1){1'b1}}, 1'b0};
  if (PRESCALE < 1 || DEAD < 1) begin : g_bad_param
    $error("PRESCALE and DEAD must both be >= 1");
  end
  logic [PW-1:0]    prescaler;
  logic [WIDTH-1:0] cnt, active, shadow;
  logic             pending, tick, wrap, accept, raw;
  assign tick       = enable && prescaler == PW'(PRESCALE - 1);
  assign wrap       = tick && cnt == LAST;
  assign duty_ready = !pending;
  assign accept     = duty_valid && !pending;
  assign raw        = enable && cnt < active;
  // While disabled there is no period to protect, so a pending word is adopted at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler    <= '0;
      cnt          <= '0;
      active       <= '0;
      shadow       <= '0;
      pending      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      prescaler    <= (!enable || tick) ? '0 : prescaler + 1'b1;
      cnt          <= (!enable || wrap) ? '0 : tick ? cnt + 1'b1 : cnt;
      period_start <= wrap;
      if (pending && (wrap || !enable)) begin
        active  <= shadow;
        pending <= 1'b0;
      end else if (accept) begin
        shadow  <= duty_in;
        pending <= 1'b1;
      end
    end
  end
`ifdef PWM_DEADTIME_EN
  typedef enum logic [1:0] {LO_ON, DEAD_LH, HI_ON, DEAD_HL} dt_state_t;
  localparam int DW = $clog2(DEAD + 2);
  dt_state_t        state, nxt;
  logic [DW-1:0]    rem, nxt_rem;
  // rem is the number of settling edges still owed; DEAD+1 after disable/rst covers the entry edge too.
  always_comb begin
    nxt     = state;
    nxt_rem = rem;
    case (state)
      LO_ON:   if (raw) begin nxt = DEAD_LH; nxt_rem = DW'(DEAD - 1); end
               else if (rem != '0) nxt_rem = rem - 1'b1;
      DEAD_LH: if (!raw) begin nxt = DEAD_HL; nxt_rem = DW'(DEAD - 1); end
               else if (rem == '0) nxt = HI_ON;
               else nxt_rem = rem - 1'b1;
      HI_ON:   if (!raw) begin nxt = DEAD_HL; nxt_rem = DW'(DEAD - 1); end
      DEAD_HL: if (raw) begin nxt = DEAD_LH; nxt_rem = DW'(DEAD - 1); end
               else if (rem == '0) nxt = LO_ON;
               else nxt_rem = rem - 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state   <= LO_ON;
      rem     <= DW'(DEAD + 1);
      pwm_out <= 1'b0;
      pwm_n   <= 1'b0;
    end else begin
      state   <= nxt;
      rem     <= nxt_rem;
      pwm_out <= nxt == HI_ON;
      pwm_n   <= nxt == LO_ON && nxt_rem == '0;
    end
  end
`else
  assign pwm_n = 1'b0;
  always_ff @(posedge clk) pwm_out <= rst ? 1'b0 : raw;
`endif
endmodule
